// File: rtl/uart_tb_pkg.sv
// Shared constants for the bench-side UART transmitter: frame geometry,
// idle line level and FSM state encodings.
package uart_tb_pkg;

  localparam int unsigned UART_DATA_BITS  = 8;
  localparam logic        UART_IDLE_LEVEL = 1'b1;

  localparam int unsigned ST_W = 3;
  localparam logic [ST_W-1:0] ST_IDLE   = 3'd0;
  localparam logic [ST_W-1:0] ST_START  = 3'd1;
  localparam logic [ST_W-1:0] ST_DATA   = 3'd2;
  localparam logic [ST_W-1:0] ST_PARITY = 3'd3;
  localparam logic [ST_W-1:0] ST_STOP   = 3'd4;

  // Even parity bit over one data byte.
  function automatic logic even_parity(input logic [UART_DATA_BITS-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/uart_tb_fifo.sv
// Synchronous byte FIFO with registered full/empty flags. A push while full
// is dropped even if a pop happens in the same cycle.
module uart_tb_fifo
  import uart_tb_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic             full_q;
  logic             empty_q;
  logic             do_push;
  logic             do_pop;

  assign do_push = push_i && !full_q;
  assign do_pop  = pop_i && !empty_q;
  assign rdata_o = mem_q[rd_ptr_q];
  assign full_o  = full_q;
  assign empty_o = empty_q;

  // Occupancy after this cycle's push/pop.
  always_comb begin
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage array; contents are don't-care while the slot is unoccupied.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  // Pointers, occupancy and flags; reset flushes the FIFO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_d;
      full_q  <= (count_d == CNT_W'(DEPTH));
      empty_q <= (count_d == '0);
    end
  end

endmodule

// File: rtl/uart_tb_tx.sv
// Bench-side UART transmitter: serialises queued bytes into 8N1 frames timed
// by rising edges of BAUDTICK. Define UART_TB_TX_PARITY_EN to insert an
// even-parity bit between the data bits and the stop bit(s).
module uart_tb_tx
  import uart_tb_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH    = 16,
  parameter int unsigned TICKS_PER_BIT = 16,
  parameter int unsigned STOP_BITS     = 1
) (
  input  logic        CLK,
  input  logic        RESETn,
  input  logic        BAUDTICK,
  input  logic [7:0]  DATA_IN,
  input  logic        DATA_VALID,
  output logic        DATA_READY,
  output logic        TXD,
  output logic        BUSY,
  output logic [15:0] TX_COUNT
);

  localparam int unsigned CNT_W     = $clog2(TICKS_PER_BIT * 2);
  localparam int unsigned BIDX_W    = $clog2(UART_DATA_BITS);
  localparam logic [CNT_W-1:0]  BIT_LAST  = CNT_W'(TICKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]  STOP_LAST = CNT_W'(STOP_BITS * TICKS_PER_BIT - 1);
  localparam logic [BIDX_W-1:0] BIDX_LAST = BIDX_W'(UART_DATA_BITS - 1);

  logic [ST_W-1:0]           state_q,    state_d;
  logic [UART_DATA_BITS-1:0] shift_q,    shift_d;
  logic [BIDX_W-1:0]         bit_idx_q,  bit_idx_d;
  logic [CNT_W-1:0]          tick_cnt_q, tick_cnt_d;
  logic                      txd_q,      txd_d;
  logic [15:0]               tx_count_q, tx_count_d;
  logic                      baud_q;

  logic                      tick_c;
  logic                      pop_c;
  logic                      busy_c;
  logic                      fifo_full;
  logic                      fifo_empty;
  logic [UART_DATA_BITS-1:0] fifo_rdata;

  uart_tb_fifo #(
    .WIDTH (UART_DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (CLK),
    .rst_n   (RESETn),
    .push_i  (DATA_VALID),
    .wdata_i (DATA_IN),
    .pop_i   (pop_c),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign tick_c     = BAUDTICK && !baud_q;
  assign busy_c     = (state_q != ST_IDLE) || !fifo_empty;
  assign DATA_READY = !fifo_full;
  assign TXD        = txd_q;
  assign BUSY       = busy_c;
  assign TX_COUNT   = tx_count_q;

  // Frame sequencing; txd_d is the line level for the state being entered.
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_idx_d  = bit_idx_q;
    tick_cnt_d = tick_cnt_q;
    txd_d      = txd_q;
    tx_count_d = tx_count_q;
    pop_c      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        txd_d = UART_IDLE_LEVEL;
        if (!fifo_empty) begin
          pop_c      = 1'b1;
          shift_d    = fifo_rdata;
          tick_cnt_d = '0;
          state_d    = ST_START;
          txd_d      = 1'b0;
        end
      end
      ST_START: begin
        if (tick_c) begin
          if (tick_cnt_q == BIT_LAST) begin
            tick_cnt_d = '0;
            bit_idx_d  = '0;
            state_d    = ST_DATA;
            txd_d      = shift_q[0];
          end else begin
            tick_cnt_d = tick_cnt_q + CNT_W'(1);
          end
        end
      end
      ST_DATA: begin
        if (tick_c) begin
          if (tick_cnt_q == BIT_LAST) begin
            tick_cnt_d = '0;
            if (bit_idx_q == BIDX_LAST) begin
`ifdef UART_TB_TX_PARITY_EN
              state_d = ST_PARITY;
              txd_d   = even_parity(shift_q);
`else
              state_d = ST_STOP;
              txd_d   = UART_IDLE_LEVEL;
`endif
            end else begin
              bit_idx_d = bit_idx_q + BIDX_W'(1);
              txd_d     = shift_q[bit_idx_q + BIDX_W'(1)];
            end
          end else begin
            tick_cnt_d = tick_cnt_q + CNT_W'(1);
          end
        end
      end
`ifdef UART_TB_TX_PARITY_EN
      ST_PARITY: begin
        if (tick_c) begin
          if (tick_cnt_q == BIT_LAST) begin
            tick_cnt_d = '0;
            state_d    = ST_STOP;
            txd_d      = UART_IDLE_LEVEL;
          end else begin
            tick_cnt_d = tick_cnt_q + CNT_W'(1);
          end
        end
      end
`endif
      ST_STOP: begin
        txd_d = UART_IDLE_LEVEL;
        if (tick_c) begin
          if (tick_cnt_q == STOP_LAST) begin
            tick_cnt_d = '0;
            state_d    = ST_IDLE;
            tx_count_d = tx_count_q + 16'd1;
          end else begin
            tick_cnt_d = tick_cnt_q + CNT_W'(1);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        txd_d   = UART_IDLE_LEVEL;
      end
    endcase
  end

  // State, datapath and tick edge-detect registers; reset aborts any frame.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state_q    <= ST_IDLE;
      shift_q    <= '0;
      bit_idx_q  <= '0;
      tick_cnt_q <= '0;
      txd_q      <= UART_IDLE_LEVEL;
      tx_count_q <= '0;
      baud_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_idx_q  <= bit_idx_d;
      tick_cnt_q <= tick_cnt_d;
      txd_q      <= txd_d;
      tx_count_q <= tx_count_d;
      baud_q     <= BAUDTICK;
    end
  end

endmodule

// File: tb/tb_uart_tb_tx.sv
// Directed bench for uart_tb_tx: timing of frames, FIFO handshake, tick edge
// detection, back-to-back gap and mid-frame reset. Parity case is built only
// with UART_TB_TX_PARITY_EN.
module tb_uart_tb_tx;

  localparam int unsigned TPB = 16;

  logic        CLK = 1'b0;
  logic        RESETn;
  logic        BAUDTICK;
  logic [7:0]  DATA_IN;
  logic        DATA_VALID;
  logic        DATA_READY;
  logic        TXD;
  logic        BUSY;
  logic [15:0] TX_COUNT;

  int n_checks = 0;
  int n_pass   = 0;
  int baud_period = 4;
  int baud_hi     = 1;
  int cyc = 0;

  int         edge_q[$];
  int         cnt_q[$];
  logic [7:0] rx_q[$];
  logic       rx_par_q[$];

  uart_tb_tx dut (
    .CLK        (CLK),
    .RESETn     (RESETn),
    .BAUDTICK   (BAUDTICK),
    .DATA_IN    (DATA_IN),
    .DATA_VALID (DATA_VALID),
    .DATA_READY (DATA_READY),
    .TXD        (TXD),
    .BUSY       (BUSY),
    .TX_COUNT   (TX_COUNT)
  );

  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Baud tick source: high for baud_hi cycles out of every baud_period.
  initial begin
    int c;
    c = 0;
    BAUDTICK = 1'b0;
    forever begin
      @(negedge CLK);
      if (c >= baud_period - 1) c = 0;
      else c++;
      BAUDTICK = (c < baud_hi);
    end
  end

  // Timestamps of TXD transitions and TX_COUNT changes.
  initial begin
    logic        tp;
    logic [15:0] cp;
    tp = 1'b1;
    cp = '0;
    forever begin
      @(negedge CLK);
      cyc++;
      if (TXD !== tp) edge_q.push_back(cyc);
      tp = TXD;
      if (TX_COUNT !== cp) cnt_q.push_back(cyc);
      cp = TX_COUNT;
    end
  end

  // Independent receiver: mid-bit sampling timed in clock cycles.
  initial begin
    forever begin
      @(negedge CLK);
      if (TXD === 1'b0 && RESETn === 1'b1) begin
        int bp;
        logic [7:0] b;
        bp = baud_period * TPB;
        b  = '0;
        repeat (bp / 2) @(negedge CLK);
        if (TXD === 1'b0) begin
          for (int i = 0; i < 8; i++) begin
            repeat (bp) @(negedge CLK);
            b[i] = TXD;
          end
`ifdef UART_TB_TX_PARITY_EN
          repeat (bp) @(negedge CLK);
          rx_par_q.push_back(TXD);
`endif
          repeat (bp) @(negedge CLK);
          rx_q.push_back(b);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic clear_logs();
    edge_q.delete();
    cnt_q.delete();
    rx_q.delete();
    rx_par_q.delete();
  endtask

  task automatic apply_reset();
    @(negedge CLK);
    RESETn = 1'b0;
    repeat (3) @(negedge CLK);
    RESETn = 1'b1;
    repeat (2) @(negedge CLK);
    clear_logs();
  endtask

  task automatic push_byte(input logic [7:0] b);
    @(negedge CLK);
    DATA_IN    = b;
    DATA_VALID = 1'b1;
    @(negedge CLK);
    DATA_VALID = 1'b0;
  endtask

  task automatic wait_count(input logic [15:0] target, input int budget, input string tag);
    int n;
    n = 0;
    while (TX_COUNT !== target && n < budget) begin
      @(negedge CLK);
      n++;
    end
    check_eq(tag, 32'(TX_COUNT), 32'(target));
  endtask

  task automatic check_bits(input string tag, input int len);
    check_eq({tag, "_edges"}, 32'(edge_q.size()), 32'd10);
    if (edge_q.size() == 10) begin
      for (int i = 1; i <= 8; i++)
        check_eq($sformatf("%s_bit%0d_len", tag, i - 1), 32'(edge_q[i+1] - edge_q[i]), 32'(len));
    end
  endtask

  initial begin
    int acc;
    int guard;
    int bad;
    int gap;

    RESETn     = 1'b0;
    DATA_VALID = 1'b0;
    DATA_IN    = '0;
    repeat (3) @(negedge CLK);
    check_eq("rst_txd",   32'(TXD),        32'd1);
    check_eq("rst_ready", 32'(DATA_READY), 32'd1);
    check_eq("rst_busy",  32'(BUSY),       32'd0);
    check_eq("rst_count", 32'(TX_COUNT),   32'd0);
    RESETn = 1'b1;
    repeat (2) @(negedge CLK);
    clear_logs();

    // Single 0x55 frame, tick every 4 clocks: 64 clocks per bit.
    baud_period = 4; baud_hi = 1;
    @(negedge CLK);
    DATA_IN = 8'h55; DATA_VALID = 1'b1;
    @(negedge CLK);
    DATA_VALID = 1'b0;
    check_eq("t1_txd_hold", 32'(TXD),  32'd1);
    check_eq("t1_busy",     32'(BUSY), 32'd1);
    @(negedge CLK);
    check_eq("t1_txd_fall", 32'(TXD),  32'd0);
    wait_count(16'd1, 2000, "t1_count");
    check_eq("t1_busy_end", 32'(BUSY), 32'd0);
    repeat (2) @(negedge CLK);
    check_bits("t1", 64);
    if (edge_q.size() == 10 && cnt_q.size() >= 1)
      check_eq("t1_stop_len", 32'(cnt_q[0] - edge_q[9]), 32'd64);
    check_eq("t1_rx_n", 32'(rx_q.size()), 32'd1);
    if (rx_q.size() >= 1) check_eq("t1_rx", 32'(rx_q[0]), 32'h55);

    // Burst of 17 bytes into a 16-deep FIFO.
    apply_reset();
    baud_period = 2; baud_hi = 1;
    acc = 0; guard = 0;
    while (acc < 17 && guard < 400) begin
      @(negedge CLK);
      DATA_IN = 8'(acc); DATA_VALID = 1'b1;
      #1;
      if (DATA_READY) acc++;
      guard++;
    end
    @(negedge CLK);
    DATA_VALID = 1'b0;
    check_eq("t2_accepted", 32'(acc),        32'd17);
    check_eq("t2_full",     32'(DATA_READY), 32'd0);
    wait_count(16'd1, 1000, "t2_first");
    @(negedge CLK);
    check_eq("t2_ready_back", 32'(DATA_READY), 32'd1);
    wait_count(16'd17, 8000, "t2_count");
    repeat (2) @(negedge CLK);
    check_eq("t2_rx_n", 32'(rx_q.size()), 32'd17);
    bad = 0;
    for (int i = 0; i < rx_q.size(); i++) if (rx_q[i] !== 8'(i)) bad++;
    check_eq("t2_order", 32'(bad), 32'd0);
    check_eq("t2_busy_end", 32'(BUSY), 32'd0);

    // Back-to-back 0xA5, 0x3C: one idle cycle between frames.
    baud_period = 4; baud_hi = 1;
    repeat (2) @(negedge CLK);
    clear_logs();
    @(negedge CLK);
    DATA_IN = 8'hA5; DATA_VALID = 1'b1;
    @(negedge CLK);
    DATA_IN = 8'h3C;
    @(negedge CLK);
    DATA_VALID = 1'b0;
    wait_count(16'd19, 3000, "t3_count");
    repeat (2) @(negedge CLK);
    check_eq("t3_rx_n", 32'(rx_q.size()), 32'd2);
    if (rx_q.size() == 2) begin
      check_eq("t3_rx0", 32'(rx_q[0]), 32'hA5);
      check_eq("t3_rx1", 32'(rx_q[1]), 32'h3C);
    end
    gap = -1;
    if (cnt_q.size() >= 1) begin
      foreach (edge_q[i]) if (gap < 0 && edge_q[i] > cnt_q[0]) gap = edge_q[i] - cnt_q[0];
    end
    check_eq("t3_gap", 32'(gap), 32'd1);

    // BAUDTICK held high 10 of 16 clocks: one tick per pulse, 256 clocks per bit.
    baud_period = 16; baud_hi = 10;
    repeat (20) @(negedge CLK);
    clear_logs();
    push_byte(8'h55);
    wait_count(16'd20, 5000, "t4_count");
    repeat (2) @(negedge CLK);
    check_bits("t4", 256);
    if (rx_q.size() >= 1) check_eq("t4_rx", 32'(rx_q[0]), 32'h55);

    // Mid-frame reset with bytes still queued.
    baud_period = 4; baud_hi = 1;
    repeat (8) @(negedge CLK);
    @(negedge CLK);
    DATA_IN = 8'hFF; DATA_VALID = 1'b1;
    @(negedge CLK); DATA_IN = 8'h11;
    @(negedge CLK); DATA_IN = 8'h22;
    @(negedge CLK); DATA_IN = 8'h33;
    @(negedge CLK); DATA_VALID = 1'b0;
    repeat (200) @(negedge CLK);
    check_eq("t5_busy_pre", 32'(BUSY), 32'd1);
    RESETn = 1'b0;
    #1;
    check_eq("t5_txd",   32'(TXD),        32'd1);
    check_eq("t5_busy",  32'(BUSY),       32'd0);
    check_eq("t5_ready", 32'(DATA_READY), 32'd1);
    check_eq("t5_count", 32'(TX_COUNT),   32'd0);
    repeat (3) @(negedge CLK);
    RESETn = 1'b1;
    clear_logs();
    repeat (3000) @(negedge CLK);
    check_eq("t5_no_frames", 32'(edge_q.size()), 32'd0);
    check_eq("t5_count_end", 32'(TX_COUNT),      32'd0);
    check_eq("t5_busy_end",  32'(BUSY),          32'd0);

`ifdef UART_TB_TX_PARITY_EN
    // 0x07 has three ones: even parity bit is 1, frame is 11 bits.
    apply_reset();
    push_byte(8'h07);
    wait_count(16'd1, 2000, "t6_count");
    repeat (2) @(negedge CLK);
    if (rx_q.size() >= 1)     check_eq("t6_rx",  32'(rx_q[0]),     32'h07);
    if (rx_par_q.size() >= 1) check_eq("t6_par", 32'(rx_par_q[0]), 32'd1);
    check_eq("t6_edges", 32'(edge_q.size()), 32'd4);
    if (edge_q.size() == 4 && cnt_q.size() >= 1) begin
      check_eq("t6_low_run",   32'(edge_q[3] - edge_q[2]), 32'd320);
      check_eq("t6_par_stop",  32'(cnt_q[0] - edge_q[3]),  32'd128);
    end
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
